// File: rtl/ball_dir_ctrl.sv
// Pong game-logic stage: paces the ball mover from frame ticks, resolves wall/paddle
// collisions into the next 16-step compass direction, and keeps score.
module ball_dir_ctrl #(
  parameter int unsigned MOVE_DIV    = 1,
  parameter int unsigned PADDLE_LX   = 64,
  parameter int unsigned PADDLE_RX   = 2496,
  parameter int unsigned PADDLE_HH   = 128,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [12:0] ball_x,
  input  logic [12:0] ball_y,
  input  logic [12:0] size,
  input  logic [12:0] pad_l_y,
  input  logic [12:0] pad_r_y,
  output logic [3:0]  direction,
  output logic        move,
  output logic        ball_rst,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_EVAL, S_SCORE} state_e;

  localparam logic [3:0]  DIV_LAST  = 4'(MOVE_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
  localparam logic [13:0] LX        = 14'(PADDLE_LX);
  localparam logic [13:0] RX        = 14'(PADDLE_RX);
  localparam logic [13:0] HH        = 14'(PADDLE_HH);
  localparam logic [13:0] HALF      = 14'(PADDLE_HH / 2);

  state_e      state_q, state_d;
  logic [3:0]  dir_q, dir_d;
  logic        move_q, move_d;
  logic        brst_q, brst_d;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic        over_q, over_d;
  logic [3:0]  div_q, div_d;
  logic [15:0] hold_q, hold_d;
  logic        loser_l_q, loser_l_d;
  logic        pend_q, pend_d;

  logic        tick_last, fire;
  logic [13:0] bx, by, sz, dl, dr, adl, adr;
  logic        leftward, rightward, left_hit, right_hit, miss_l, miss_r;
  logic        top_l, bot_l, top_r, bot_r, wall_top, wall_bot;
  logic [3:0]  mirror, pdir, ndir;

  assign tick_last = frame_tick && (div_q == DIV_LAST);
  // pend_q remembers a move period that completed while EVAL was busy
  assign fire      = pend_q || tick_last;

  always_comb begin
    bx        = {1'b0, ball_x};
    by        = {1'b0, ball_y};
    sz        = {1'b0, size};
    dl        = by - {1'b0, pad_l_y};
    dr        = by - {1'b0, pad_r_y};
    adl       = dl[13] ? (14'd0 - dl) : dl;
    adr       = dr[13] ? (14'd0 - dr) : dr;
    leftward  = dir_q >= 4'd9;
    rightward = (dir_q != 4'd0) && (dir_q <= 4'd7);
    left_hit  = leftward && (bx <= LX + sz) && (adl <= HH + sz);
    right_hit = rightward && (bx + sz >= RX) && (adr <= HH + sz);
    miss_l    = leftward && (bx == sz) && !left_hit;
    miss_r    = rightward && (bx + sz == 14'd2560) && !right_hit;
    top_l     = $signed(dl) < -$signed(HALF);
    bot_l     = $signed(dl) > $signed(HALF);
    top_r     = $signed(dr) < -$signed(HALF);
    bot_r     = $signed(dr) > $signed(HALF);
    mirror    = 4'd0 - dir_q;
    pdir      = dir_q;
    if (left_hit) begin
      pdir = top_l ? 4'd2 : (bot_l ? 4'd6 : mirror);
      if (pdir == 4'd0 || pdir == 4'd8) pdir = 4'd4;
    end else if (right_hit) begin
      pdir = top_r ? 4'd14 : (bot_r ? 4'd10 : mirror);
      if (pdir == 4'd0 || pdir == 4'd8) pdir = 4'd12;
    end
    // walls reflect the post-paddle direction so corner hits resolve in one pass
    wall_top = ((pdir >= 4'd13) || (pdir <= 4'd3)) && (by <= sz);
    wall_bot = (pdir >= 4'd5) && (pdir <= 4'd11) && (by + sz >= 14'd1920);
    ndir     = (wall_top || wall_bot) ? (4'd8 - pdir) : pdir;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_SERVE;
      dir_q     <= 4'd5;
      move_q    <= 1'b0;
      brst_q    <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      over_q    <= 1'b0;
      div_q     <= '0;
      hold_q    <= '0;
      loser_l_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      move_q    <= move_d;
      brst_q    <= brst_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      over_q    <= over_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      loser_l_q <= loser_l_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SERVE: if (serve && !over_q) state_d = S_PLAY;
      S_PLAY:  if (fire) state_d = S_EVAL;
      S_EVAL:  state_d = (miss_l || miss_r) ? S_SCORE : S_PLAY;
      S_SCORE: if (frame_tick && hold_q == HOLD_LAST) state_d = S_SERVE;
      default: state_d = S_SERVE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    move_d    = 1'b0;
    brst_d    = 1'b0;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    div_d     = div_q;
    hold_d    = hold_q;
    loser_l_d = loser_l_q;
    pend_d    = pend_q;
    unique case (state_q)
      S_SERVE: begin
        dir_d  = loser_l_q ? 4'd11 : 4'd5;
        div_d  = '0;
        hold_d = '0;
        pend_d = 1'b0;
      end
      S_PLAY: begin
        if (frame_tick) div_d = tick_last ? 4'd0 : div_q + 4'd1;
        if (fire) begin
          move_d = 1'b1;
          pend_d = pend_q && tick_last;
        end
      end
      S_EVAL: begin
        if (frame_tick) begin
          div_d = tick_last ? 4'd0 : div_q + 4'd1;
          if (tick_last) pend_d = 1'b1;
        end
        if (miss_l || miss_r) begin
          brst_d = 1'b1;
          div_d  = '0;
          hold_d = '0;
          pend_d = 1'b0;
          if (miss_l) begin
            score_r_d = (score_r_q == 4'd15) ? 4'd15 : score_r_q + 4'd1;
            loser_l_d = 1'b1;
          end else begin
            score_l_d = (score_l_q == 4'd15) ? 4'd15 : score_l_q + 4'd1;
            loser_l_d = 1'b0;
          end
        end else begin
          dir_d = ndir;
        end
      end
      S_SCORE: begin
        if (frame_tick) hold_d = (hold_q == HOLD_LAST) ? 16'd0 : hold_q + 16'd1;
      end
      default: ;
    endcase
    over_d = over_q || (score_l_d == WIN) || (score_r_d == WIN);
  end

  assign direction = dir_q;
  assign move      = move_q;
  assign ball_rst  = brst_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Directed bench for ball_dir_ctrl (MOVE_DIV=2, other parameters default, size=8).
module tb_ball_dir_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        serve = 1'b0;
  logic [12:0] ball_x = 13'd1280, ball_y = 13'd960, size = 13'd8;
  logic [12:0] pad_l_y = 13'd960, pad_r_y = 13'd960;
  logic [3:0]  direction, score_l, score_r;
  logic        move, ball_rst, game_over;
  int total = 0;
  int bad   = 0;

  ball_dir_ctrl #(.MOVE_DIV(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .size(size), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .direction(direction), .move(move), .ball_rst(ball_rst),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic pulse_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic pulse_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
  endtask

  task automatic set_ball(input int bx, input int by, input int pl, input int pr);
    ball_x = 13'(bx); ball_y = 13'(by); pad_l_y = 13'(pl); pad_r_y = 13'(pr);
  endtask

  // ticks until a move strobe appears (bounded), then lets EVAL finish
  task automatic move_once(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      pulse_tick();
      if (move === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step_dir(input string name, input int bx, input int by, input int pl,
                          input int pr, input logic [3:0] exp);
    bit seen;
    set_ball(bx, by, pl, pr);
    move_once(seen);
    total++;
    if ({seen, direction} !== {1'b1, exp}) begin
      bad++;
      $display("FAIL %s move_seen=%0b dir=%0d exp_dir=%0d", name, seen, direction, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (direction !== 4'd5) begin bad++; $display("FAIL rst_dir got=%0d exp=5", direction); end
    total++;
    if (ball_rst !== 1'b1) begin bad++; $display("FAIL rst_ballrst got=%0b exp=1", ball_rst); end
    total++;
    if ({move, score_l, score_r, game_over} !== 10'd0) begin
      bad++; $display("FAIL rst_zero move=%0b sl=%0d sr=%0d go=%0b exp=0", move, score_l, score_r, game_over);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ball_rst, direction} !== {1'b0, 4'd5}) begin
      bad++; $display("FAIL rst_release ballrst=%0b dir=%0d exp 0/5", ball_rst, direction);
    end
  endtask

  task automatic test_pacing();
    int n = 0;
    repeat (4) begin pulse_tick(); n += int'(move); @(negedge clk); n += int'(move); end
    total++;
    if (n != 0) begin bad++; $display("FAIL no_move_before_serve got=%0d exp=0", n); end
    pulse_serve();
    @(negedge clk);
    total++;
    if (direction !== 4'd5) begin bad++; $display("FAIL serve_dir got=%0d exp=5", direction); end
    n = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      n += int'(move);
      frame_tick = (i % 4 == 0) && (i < 24);
    end
    frame_tick = 1'b0;
    total++;
    if (n != 3) begin bad++; $display("FAIL pacing_moves got=%0d exp=3", n); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n += int'(move);
      frame_tick = (i < 8);
    end
    frame_tick = 1'b0;
    total++;
    if (n != 4) begin bad++; $display("FAIL b2b_moves got=%0d exp=4", n); end
  endtask

  task automatic test_walls();
    step_dir("wall_bot_5",   1280, 1912, 960, 960, 4'd3);
    step_dir("wall_top_3",   1280,    8, 960, 960, 4'd5);
    step_dir("wall_bot_5b",  1280, 1912, 960, 960, 4'd3);
    step_dir("corner_r_top", 2488,    8, 960,  60, 4'd11);
    step_dir("wall_bot_11",  1280, 1912, 960, 960, 4'd13);
    step_dir("wall_top_13",  1280,    8, 960, 960, 4'd11);
  endtask

  task automatic test_paddle();
    step_dir("lpad_mid",    72,  960, 960, 960, 4'd5);
    step_dir("rpad_mid",  2488,  960, 960, 960, 4'd11);
    step_dir("lpad_bot",    72, 1060, 960, 960, 4'd6);
    step_dir("wall_bot_6", 1280, 1912, 960, 960, 4'd2);
    step_dir("rpad_mid_2", 2488, 960, 960, 960, 4'd14);
    step_dir("lpad_top",    72,  860, 960, 960, 4'd2);
    step_dir("rpad_mid_3", 2488, 960, 960, 960, 4'd14);
  endtask

  task automatic test_miss();
    bit seen;
    int n = 0;
    set_ball(8, 960, 1800, 960);
    move_once(seen);
    total++;
    if ({seen, ball_rst, score_r, score_l} !== {1'b1, 1'b1, 4'd1, 4'd0}) begin
      bad++; $display("FAIL left_miss seen=%0b ballrst=%0b sr=%0d sl=%0d exp 1/1/1/0", seen, ball_rst, score_r, score_l);
    end
    @(negedge clk);
    total++;
    if (ball_rst !== 1'b0) begin bad++; $display("FAIL ballrst_width got=%0b exp=0", ball_rst); end
    set_ball(1280, 960, 960, 960);
    repeat (59) begin pulse_tick(); n += int'(move); end
    pulse_serve();
    @(negedge clk);
    total++;
    if ({n, direction} !== {32'd0, 4'd14}) begin
      bad++; $display("FAIL hold_59 moves=%0d dir=%0d exp 0/14", n, direction);
    end
    pulse_tick();
    @(negedge clk);
    total++;
    if (direction !== 4'd11) begin bad++; $display("FAIL reserve_dir got=%0d exp=11", direction); end
    pulse_serve();
    step_dir("play_after_reserve", 1280, 960, 960, 960, 4'd11);
  endtask

  task automatic test_game_over();
    bit seen;
    int n = 0;
    step_dir("go_bounce", 72, 960, 960, 960, 4'd5);
    for (int r = 1; r <= 9; r++) begin
      set_ball(2552, 960, 960, 100);
      move_once(seen);
      total++;
      if ({seen, score_l, game_over} !== {1'b1, 4'(r), (r == 9)}) begin
        bad++; $display("FAIL right_miss_%0d seen=%0b sl=%0d go=%0b exp_sl=%0d", r, seen, score_l, game_over, r);
      end
      set_ball(1280, 960, 960, 960);
      repeat (60) pulse_tick();
      @(negedge clk);
      total++;
      if (direction !== 4'd5) begin bad++; $display("FAIL serve_dir_r%0d got=%0d exp=5", r, direction); end
      if (r < 9) pulse_serve();
    end
    pulse_serve();
    repeat (4) begin pulse_tick(); n += int'(move); end
    total++;
    if ({n, game_over, score_r} !== {32'd0, 1'b1, 4'd1}) begin
      bad++; $display("FAIL serve_ignored moves=%0d go=%0b sr=%0d exp 0/1/1", n, game_over, score_r);
    end
  endtask

  task automatic test_reset_mid_play();
    bit seen;
    int n = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulse_serve();
    set_ball(2552, 960, 960, 100);
    move_once(seen);
    total++;
    if ({seen, score_l, game_over} !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL after_rst_miss seen=%0b sl=%0d go=%0b exp 1/1/0", seen, score_l, game_over);
    end
    set_ball(1280, 960, 960, 960);
    repeat (60) pulse_tick();
    pulse_serve();
    pulse_tick();
    #3 rst = 1'b0;
    #1;
    total++;
    if ({direction, score_l, score_r, ball_rst, move, game_over} !== {4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_rst dir=%0d sl=%0d sr=%0d ballrst=%0b move=%0b go=%0b exp 5/0/0/1/0/0",
                      direction, score_l, score_r, ball_rst, move, game_over);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) begin pulse_tick(); n += int'(move); end
    total++;
    if (n != 0) begin bad++; $display("FAIL rst_to_serve moves=%0d exp=0", n); end
    pulse_serve();
    step_dir("play_after_rst", 1280, 960, 960, 960, 4'd5);
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_back_to_back();
    test_walls();
    test_paddle();
    test_miss();
    test_game_over();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
